mem_access_ctrl: RTL and testbench

// MEM-stage load/store engine; consumes EX/MEM pipeline-register outputs and drives data-memory bus.

---
 rtl/mem_access_ctrl_if.sv | 34 +++
 rtl/mem_access_ctrl.sv | 253 +++++++++++++++++++++++++
 tb/tb_mem_access_ctrl.sv | 334 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_access_ctrl_if.sv
// Data-memory bus between the MEM-stage load/store engine and memory.
// Single outstanding request; load data returns on the rsp channel.
interface mem_access_ctrl_if;
  logic        req_valid_o;
  logic        req_ready_i;
  logic        req_we_o;
  logic [31:0] req_addr_o;
  logic [3:0]  req_wstrb_o;
  logic [31:0] req_wdata_o;
  logic        rsp_valid_i;
  logic [31:0] rsp_rdata_i;

  modport master (
    output req_valid_o,
    output req_we_o,
    output req_addr_o,
    output req_wstrb_o,
    output req_wdata_o,
    input  req_ready_i,
    input  rsp_valid_i,
    input  rsp_rdata_i
  );

  modport slave (
    input  req_valid_o,
    input  req_we_o,
    input  req_addr_o,
    input  req_wstrb_o,
    input  req_wdata_o,
    output req_ready_i,
    output rsp_valid_i,
    output rsp_rdata_i
  );
endinterface

// File: rtl/mem_access_ctrl.sv
// MEM-stage load/store engine: one bus access per load/store,
// lane alignment, load extension, stall and timed-out abort.
module mem_access_ctrl #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        r_mem_enable_i,
  input  logic [31:0] r_mem_addr_i,
  input  logic        w_mem_enable_i,
  input  logic [31:0] w_mem_addr_i,
  input  logic [31:0] w_mem_data_i,
  input  logic [2:0]  data_type_i,
  input  logic        mem_w_reg_enable_i,
  input  logic [4:0]  w_reg_addr_i,
  mem_access_ctrl_if.master bus,
  output logic        stall_req_o,
  output logic        mem_w_reg_enable_o,
  output logic [4:0]  w_reg_addr_o,
  output logic [31:0] mem_w_reg_data_o,
  output logic        misalign_o,
  output logic        bus_err_o
);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT_R,
    DONE
  } state_t;

  typedef enum logic [1:0] {
    SZ_B,
    SZ_H,
    SZ_W
  } size_t;

  state_t      state;
  state_t      state_nxt;
  logic [15:0] cnt;
  logic [16:0] cnt_inc;
  logic        tmo_hit;

  logic        pending;
  logic        is_store;
  logic [31:0] addr;
  size_t       size;
  logic        sgn;
  logic        misal;
  logic [3:0]  wstrb;
  logic [31:0] wdata;

  logic        abort;
  logic        capture;

  logic        req_valid_q;
  logic        req_we_q;
  logic [31:0] req_addr_q;
  logic [3:0]  req_wstrb_q;
  logic [31:0] req_wdata_q;

  logic [1:0]  lo_q;
  size_t       size_q;
  logic        sgn_q;
  logic        ld_wben_q;
  logic [4:0]  ld_rd_q;

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_data;

  logic        wb_en_q;
  logic [4:0]  wb_rd_q;
  logic [31:0] wb_data_q;
  logic        mis_q;
  logic        err_q;

  // Access decode; a store shadows a simultaneous load
  always_comb begin
    pending  = r_mem_enable_i | w_mem_enable_i;
    is_store = w_mem_enable_i;
    addr     = is_store ? w_mem_addr_i : r_mem_addr_i;
    size     = SZ_W;
    sgn      = 1'b0;
    unique case (1'b1)
      (data_type_i == 3'd1): begin
        size = SZ_B;
        sgn  = 1'b1;
      end
      (data_type_i == 3'd4): size = SZ_B;
      (data_type_i == 3'd2): begin
        size = SZ_H;
        sgn  = 1'b1;
      end
      (data_type_i == 3'd5): size = SZ_H;
      default: size = SZ_W;
    endcase
  end

  always_comb begin
    misal = 1'b0;
    wstrb = 4'b1111;
    wdata = w_mem_data_i;
    unique case (size)
      SZ_B: begin
        wstrb = 4'b0001 << addr[1:0];
        wdata = {4{w_mem_data_i[7:0]}};
      end
      SZ_H: begin
        misal = addr[0];
        wstrb = addr[1] ? 4'b1100 : 4'b0011;
        wdata = {2{w_mem_data_i[15:0]}};
      end
      default: begin
        misal = (addr[1:0] != 2'b00);
      end
    endcase
  end

  assign cnt_inc = {1'b0, cnt} + 17'd1;
  assign tmo_hit = (cnt_inc >= 17'(TIMEOUT));

  always_comb begin
    state_nxt = state;
    abort     = 1'b0;
    capture   = 1'b0;
    unique case (state)
      IDLE: begin
        if (pending)
          state_nxt = misal ? DONE : REQ;
      end
      REQ: begin
        if (bus.req_ready_i) begin
          state_nxt = req_we_q ? DONE : WAIT_R;
        end else if (tmo_hit) begin
          state_nxt = DONE;
          abort     = 1'b1;
        end
      end
      WAIT_R: begin
        if (bus.rsp_valid_i) begin
          state_nxt = DONE;
          capture   = 1'b1;
        end else if (tmo_hit) begin
          state_nxt = DONE;
          abort     = 1'b1;
        end
      end
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Reset gates stall so it drops at once with the FSM
  always_comb begin
    stall_req_o = 1'b0;
    unique case (state)
      IDLE:   stall_req_o = pending;
      REQ:    stall_req_o = 1'b1;
      WAIT_R: stall_req_o = 1'b1;
      default: stall_req_o = 1'b0;
    endcase
    stall_req_o = stall_req_o & ~rst;
  end

  always_comb begin
    unique case (lo_q)
      2'd0: ld_byte = bus.rsp_rdata_i[7:0];
      2'd1: ld_byte = bus.rsp_rdata_i[15:8];
      2'd2: ld_byte = bus.rsp_rdata_i[23:16];
      default: ld_byte = bus.rsp_rdata_i[31:24];
    endcase
    ld_half = lo_q[1] ? bus.rsp_rdata_i[31:16]
                      : bus.rsp_rdata_i[15:0];
    unique case (size_q)
      SZ_B: ld_data = {{24{sgn_q & ld_byte[7]}}, ld_byte};
      SZ_H: ld_data = {{16{sgn_q & ld_half[15]}}, ld_half};
      default: ld_data = bus.rsp_rdata_i;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      req_valid_q <= 1'b0;
      req_we_q    <= 1'b0;
      req_addr_q  <= '0;
      req_wstrb_q <= '0;
      req_wdata_q <= '0;
      lo_q        <= '0;
      size_q      <= SZ_W;
      sgn_q       <= 1'b0;
      ld_wben_q   <= 1'b0;
      ld_rd_q     <= '0;
      wb_en_q     <= 1'b0;
      wb_rd_q     <= '0;
      wb_data_q   <= '0;
      mis_q       <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state   <= state_nxt;
      mis_q   <= 1'b0;
      err_q   <= 1'b0;
      wb_en_q <= 1'b0;
      if (state == REQ || state == WAIT_R)
        cnt <= cnt_inc[15:0];
      else
        cnt <= '0;
      if (state == IDLE && pending) begin
        if (misal) begin
          mis_q     <= 1'b1;
          wb_data_q <= '0;
        end else begin
          req_valid_q <= 1'b1;
          req_we_q    <= is_store;
          req_addr_q  <= {addr[31:2], 2'b00};
          req_wstrb_q <= is_store ? wstrb : 4'b0000;
          req_wdata_q <= is_store ? wdata : 32'd0;
          lo_q        <= addr[1:0];
          size_q      <= size;
          sgn_q       <= sgn;
          ld_wben_q   <= mem_w_reg_enable_i;
          ld_rd_q     <= w_reg_addr_i;
        end
      end
      if (state == REQ && (bus.req_ready_i || abort))
        req_valid_q <= 1'b0;
      if (abort) begin
        err_q     <= 1'b1;
        wb_data_q <= '0;
      end
      if (capture) begin
        wb_en_q   <= ld_wben_q;
        wb_rd_q   <= ld_rd_q;
        wb_data_q <= ld_data;
      end
    end
  end

  assign bus.req_valid_o  = req_valid_q;
  assign bus.req_we_o     = req_we_q;
  assign bus.req_addr_o   = req_addr_q;
  assign bus.req_wstrb_o  = req_wstrb_q;
  assign bus.req_wdata_o  = req_wdata_q;

  assign mem_w_reg_enable_o = wb_en_q;
  assign w_reg_addr_o       = wb_rd_q;
  assign mem_w_reg_data_o   = wb_data_q;
  assign misalign_o         = mis_q;
  assign bus_err_o          = err_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl: loads, stores, misalign,
// timeout abort and reset in flight, with hand-computed results.
module tb_mem_access_ctrl;
  logic        clk = 1'b0;
  logic        rst;
  logic        r_en;
  logic [31:0] r_addr;
  logic        w_en;
  logic [31:0] w_addr;
  logic [31:0] w_data;
  logic [2:0]  dt;
  logic        wben;
  logic [4:0]  rd;
  logic        stall;
  logic        wb_en;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        mis;
  logic        err;
  int          total = 0;
  int          bad = 0;

  mem_access_ctrl_if bus ();

  mem_access_ctrl #(.TIMEOUT(8)) dut (
    .clk                (clk),
    .rst                (rst),
    .r_mem_enable_i     (r_en),
    .r_mem_addr_i       (r_addr),
    .w_mem_enable_i     (w_en),
    .w_mem_addr_i       (w_addr),
    .w_mem_data_i       (w_data),
    .data_type_i        (dt),
    .mem_w_reg_enable_i (wben),
    .w_reg_addr_i       (rd),
    .bus                (bus),
    .stall_req_o        (stall),
    .mem_w_reg_enable_o (wb_en),
    .w_reg_addr_o       (wb_rd),
    .mem_w_reg_data_o   (wb_data),
    .misalign_o         (mis),
    .bus_err_o          (err)
  );

  always #5 clk = ~clk;

  task automatic nxt;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    r_en = 0; r_addr = 0; w_en = 0; w_addr = 0;
    w_data = 0; dt = 0; wben = 0; rd = 0;
    bus.req_ready_i = 0;
    bus.rsp_valid_i = 0;
    bus.rsp_rdata_i = 0;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if ({bus.req_valid_o, bus.req_we_o, bus.req_addr_o,
         bus.req_wstrb_o, bus.req_wdata_o, stall, wb_en,
         wb_rd, wb_data, mis, err} !== '0) begin
      bad++;
      $display("FAIL reset_outs got=%b%b%h exp=0", bus.req_valid_o,
               wb_en, wb_data);
    end
    r_en = 1'b1;
    #1;
    total++;
    if (stall !== 1'b0) begin
      bad++;
      $display("FAIL reset_stall got=%b exp=0", stall);
    end
    r_en = 1'b0;
    nxt;
    rst = 1'b0;
  endtask

  task automatic run_load(input logic [31:0] a, input logic [2:0] ty,
                          input logic [31:0] rdata, input logic [4:0] r,
                          input logic we, input logic [31:0] exp);
    nxt;
    r_en = 1; r_addr = a; dt = ty; wben = we; rd = r;
    bus.req_ready_i = 1;
    #1;
    total++;
    if ({stall, bus.req_valid_o} !== 2'b10) begin
      bad++;
      $display("FAIL ld_idle got=%b exp=10", {stall, bus.req_valid_o});
    end
    nxt;
    #1;
    total++;
    if ({bus.req_valid_o, bus.req_we_o, bus.req_addr_o, stall} !==
        {1'b1, 1'b0, a[31:2], 2'b00, 1'b1}) begin
      bad++;
      $display("FAIL ld_req got v=%b we=%b a=%h exp a=%h",
               bus.req_valid_o, bus.req_we_o, bus.req_addr_o,
               {a[31:2], 2'b00});
    end
    nxt;
    bus.req_ready_i = 0;
    bus.rsp_valid_i = 1;
    bus.rsp_rdata_i = rdata;
    #1;
    total++;
    if ({stall, bus.req_valid_o, wb_en} !== 3'b100) begin
      bad++;
      $display("FAIL ld_wait got=%b exp=100",
               {stall, bus.req_valid_o, wb_en});
    end
    nxt;
    bus.rsp_valid_i = 0;
    bus.rsp_rdata_i = 32'h5555_5555;
    r_en = 0;
    #1;
    total++;
    if ({wb_en, wb_rd, wb_data, stall} !== {we, r, exp, 1'b0}) begin
      bad++;
      $display("FAIL ld_done got en=%b rd=%0d d=%h st=%b exp %b %0d %h 0",
               wb_en, wb_rd, wb_data, stall, we, r, exp);
    end
  endtask

  task automatic test_lb;
    run_load(32'h0000_1003, 3'd1, 32'h80FF_0000, 5'd5, 1'b1,
             32'hFFFF_FF80);
    nxt;
    #1;
    total++;
    if ({wb_en, wb_data, stall} !== {1'b0, 32'hFFFF_FF80, 1'b0}) begin
      bad++;
      $display("FAIL lb_pulse got en=%b d=%h exp 0 ffffff80",
               wb_en, wb_data);
    end
  endtask

  task automatic test_lh;
    run_load(32'h0000_2002, 3'd5, 32'hBEEF_1234, 5'd9, 1'b1,
             32'h0000_BEEF);
    run_load(32'h0000_2002, 3'd2, 32'hBEEF_1234, 5'd10, 1'b1,
             32'hFFFF_BEEF);
    run_load(32'h0000_2000, 3'd2, 32'hBEEF_8234, 5'd11, 1'b0,
             32'hFFFF_8234);
    run_load(32'h0000_2001, 3'd4, 32'h0000_9900, 5'd12, 1'b1,
             32'h0000_0099);
    run_load(32'h0000_2004, 3'd0, 32'hCAFE_F00D, 5'd13, 1'b1,
             32'hCAFE_F00D);
  endtask

  task automatic run_store(input logic [31:0] a, d, input logic [2:0] ty,
                           input int dly, input logic both,
                           input logic [31:0] ea, input logic [3:0] es,
                           input logic [31:0] ed);
    int st;
    nxt;
    w_en = 1; w_addr = a; w_data = d; dt = ty;
    r_en = both; r_addr = 32'h0000_0F01;
    bus.req_ready_i = 0;
    #1;
    st = int'(stall);
    total++;
    if (bus.req_valid_o !== 1'b0) begin
      bad++;
      $display("FAIL st_idle got=%b exp=0", bus.req_valid_o);
    end
    for (int i = 0; i <= dly; i++) begin
      nxt;
      bus.req_ready_i = (i == dly);
      #1;
      st += int'(stall);
      total++;
      if ({bus.req_valid_o, bus.req_we_o, bus.req_addr_o,
           bus.req_wstrb_o, bus.req_wdata_o} !==
          {1'b1, 1'b1, ea, es, ed}) begin
        bad++;
        $display("FAIL st_req%0d got v=%b a=%h s=%b d=%h exp %h %b %h",
                 i, bus.req_valid_o, bus.req_addr_o, bus.req_wstrb_o,
                 bus.req_wdata_o, ea, es, ed);
      end
    end
    nxt;
    bus.req_ready_i = 0;
    w_en = 0;
    r_en = 0;
    #1;
    total++;
    if ({stall, bus.req_valid_o, wb_en, mis, err} !== 5'b0) begin
      bad++;
      $display("FAIL st_done got=%b exp=00000",
               {stall, bus.req_valid_o, wb_en, mis, err});
    end
    total++;
    if (st !== dly + 2) begin
      bad++;
      $display("FAIL st_stall got=%0d exp=%0d", st, dly + 2);
    end
  endtask

  task automatic test_sb_delay;
    run_store(32'h0000_0013, 32'h0000_00AB, 3'd1, 3, 1'b0,
              32'h0000_0010, 4'b1000, 32'hABAB_ABAB);
  endtask

  task automatic test_back_to_back;
    run_store(32'h0000_0100, 32'h1234_5678, 3'd3, 0, 1'b1,
              32'h0000_0100, 4'b1111, 32'h1234_5678);
    run_store(32'h0000_0202, 32'h0000_CAFE, 3'd2, 0, 1'b0,
              32'h0000_0200, 4'b1100, 32'hCAFE_CAFE);
    run_store(32'h0000_0301, 32'hFFFF_FF5A, 3'd4, 1, 1'b0,
              32'h0000_0300, 4'b0010, 32'h5A5A_5A5A);
  endtask

  task automatic test_misalign;
    nxt;
    r_en = 1; r_addr = 32'h0000_0006; dt = 3'd3; wben = 1; rd = 3;
    bus.req_ready_i = 1;
    #1;
    total++;
    if ({stall, bus.req_valid_o, mis} !== 3'b100) begin
      bad++;
      $display("FAIL mis_idle got=%b exp=100",
               {stall, bus.req_valid_o, mis});
    end
    nxt;
    r_en = 0;
    #1;
    total++;
    if ({mis, wb_en, bus.req_valid_o, stall} !== 4'b1000) begin
      bad++;
      $display("FAIL mis_done got=%b exp=1000",
               {mis, wb_en, bus.req_valid_o, stall});
    end
    nxt;
    #1;
    total++;
    if ({mis, wb_en, bus.req_valid_o} !== 3'b000) begin
      bad++;
      $display("FAIL mis_after got=%b exp=000",
               {mis, wb_en, bus.req_valid_o});
    end
    bus.req_ready_i = 0;
  endtask

  task automatic test_timeout;
    int n;
    nxt;
    r_en = 1; r_addr = 32'h0000_0040; dt = 3'd3; wben = 1; rd = 4;
    bus.req_ready_i = 0;
    #1;
    n = 0;
    for (int i = 0; i < 30; i++) begin
      nxt;
      #1;
      if (!bus.req_valid_o) break;
      n++;
    end
    total++;
    if (n !== 8) begin
      bad++;
      $display("FAIL tmo_cycles got=%0d exp=8", n);
    end
    total++;
    if ({err, wb_en, wb_data, stall} !== {1'b1, 1'b0, 32'h0, 1'b0}) begin
      bad++;
      $display("FAIL tmo_done got err=%b en=%b d=%h st=%b exp 1 0 0 0",
               err, wb_en, wb_data, stall);
    end
    r_en = 0;
    nxt;
    #1;
    total++;
    if ({err, stall, bus.req_valid_o} !== 3'b000) begin
      bad++;
      $display("FAIL tmo_idle got=%b exp=000",
               {err, stall, bus.req_valid_o});
    end
  endtask

  task automatic test_reset_wait;
    nxt;
    r_en = 1; r_addr = 32'h0000_3000; dt = 3'd3; wben = 1; rd = 7;
    bus.req_ready_i = 1;
    nxt;
    nxt;
    bus.req_ready_i = 0;
    #1;
    total++;
    if ({stall, bus.req_valid_o} !== 2'b10) begin
      bad++;
      $display("FAIL rw_wait got=%b exp=10", {stall, bus.req_valid_o});
    end
    #2;
    rst = 1'b1;
    #1;
    total++;
    if ({bus.req_valid_o, stall, wb_en, wb_data} !== 35'b0) begin
      bad++;
      $display("FAIL rw_async got v=%b s=%b en=%b d=%h exp 0",
               bus.req_valid_o, stall, wb_en, wb_data);
    end
    r_en = 0;
    nxt;
    rst = 1'b0;
    bus.rsp_valid_i = 1;
    bus.rsp_rdata_i = 32'hDEAD_BEEF;
    for (int i = 0; i < 2; i++) begin
      nxt;
      total++;
      if ({wb_en, stall, bus.req_valid_o, wb_data} !== 35'b0) begin
        bad++;
        $display("FAIL rw_late%0d got en=%b s=%b d=%h exp 0",
                 i, wb_en, stall, wb_data);
      end
    end
    bus.rsp_valid_i = 0;
  endtask

  initial begin
    test_reset;
    test_lb;
    test_lh;
    test_sb_delay;
    test_back_to_back;
    test_misalign;
    test_timeout;
    test_reset_wait;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
